kb_scan_decoder: RTL and testbench

- Sits directly downstream of the PS/2 keyboard receiver and consumes its 8-bit Set-2 scan-code bytes.
- Resolves the make, break (0xF0) and extended (0xE0) prefixes and tracks Shift state.
- Translates make codes to ASCII and buffers them in a small FIFO with a valid/ready output, for the display/UART consumer on the board clock.

---
 rtl/kb_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_kb_scan_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/kb_scan_decoder.sv
// kb_scan_decoder: PS/2 Set-2 scan codes to ASCII with Shift tracking and a FWFT output FIFO.
// Define KB_TYPEMATIC_FILTER_EN to suppress typematic repeats of the last make code.
module kb_scan_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shift_on,
    output logic       overflow,
    input  logic       ovf_clr
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t state, state_nx;
    logic shift_nx, make_ev, brk_ev, is_shift, mapped, suppress, push, pop, full, accept, drop;
    logic [7:0] letter, ascii;
    logic [8:0] other;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    assign is_shift = scan_code == 8'h12 || scan_code == 8'h59;
    always_comb begin
        letter = 8'h00;
        other  = 9'h000;
        case (scan_code)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            8'h45: other = {1'b1, 8'h30};
            8'h16: other = {1'b1, 8'h31};
            8'h1E: other = {1'b1, 8'h32};
            8'h26: other = {1'b1, 8'h33};
            8'h25: other = {1'b1, 8'h34};
            8'h2E: other = {1'b1, 8'h35};
            8'h36: other = {1'b1, 8'h36};
            8'h3D: other = {1'b1, 8'h37};
            8'h3E: other = {1'b1, 8'h38};
            8'h46: other = {1'b1, 8'h39};
            8'h29: other = {1'b1, 8'h20};
            8'h5A: other = {1'b1, 8'h0D};
            8'h66: other = {1'b1, 8'h08};
            default: other = 9'h000;
        endcase
    end
    assign mapped = letter != 8'h00 || other[8];
    assign ascii  = letter != 8'h00 ? (shift_on ? letter - 8'h20 : letter) : other[7:0];
    always_comb begin
        state_nx = state;
        shift_nx = shift_on;
        make_ev  = 1'b0;
        brk_ev   = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hF0) state_nx = BRK;
                    else if (scan_code == 8'hE0) state_nx = EXT;
                    else if (is_shift) shift_nx = 1'b1;
                    else make_ev = 1'b1;
                end
                BRK: begin
                    shift_nx = is_shift ? 1'b0 : shift_on;
                    brk_ev   = 1'b1;
                    state_nx = IDLE;
                end
                EXT:     state_nx = scan_code == 8'hF0 ? EXT_BRK : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_on <= 1'b0;
        end else begin
            state    <= state_nx;
            shift_on <= shift_nx;
        end
    end
`ifdef KB_TYPEMATIC_FILTER_EN
    logic [7:0] last_make;
    logic       last_v;
    assign suppress = last_v && last_make == scan_code;
    // Any non-shift make arms the filter; releasing that same key disarms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_make <= 8'h00;
            last_v    <= 1'b0;
        end else if (make_ev) begin
            last_make <= scan_code;
            last_v    <= 1'b1;
        end else if (brk_ev && scan_code == last_make) begin
            last_v <= 1'b0;
        end
    end
`else
    assign suppress = 1'b0;
`endif
    assign push      = make_ev && mapped && !suppress;
    assign key_valid = count != '0;
    assign key_ascii = key_valid ? mem[rd_ptr] : 8'h00;
    assign pop       = key_valid && key_ready;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= ascii;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + (AW+1)'(accept) - (AW+1)'(pop);
            overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end
endmodule

// File: tb/tb_kb_scan_decoder.sv
// tb_kb_scan_decoder: randomized and directed checks of kb_scan_decoder against a queue-based model.
module tb_kb_scan_decoder;
    localparam int DEPTH = 8;
    logic clk = 1'b0, rst_n = 1'b0, scan_valid = 1'b0, key_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] scan_code = 8'h00, key_ascii;
    logic key_valid, shift_on, overflow;
    int vectors = 0, miscompares = 0;
    kb_scan_decoder #(.FIFO_DEPTH(DEPTH), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
        .key_ascii(key_ascii), .key_valid(key_valid), .key_ready(key_ready),
        .shift_on(shift_on), .overflow(overflow), .ovf_clr(ovf_clr)
    );
    always #5 clk = ~clk;
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] mq [$];
    bit m_shift, m_ovf, m_brk, m_ext, m_lmv;
    logic [7:0] m_lm;
    function automatic logic [8:0] ref_map(input logic [7:0] c, input bit s);
        for (int i = 0; i < 26; i++)
            if (c == letter_codes[i]) return {1'b1, 8'(s ? 8'h41 + i : 8'h61 + i)};
        for (int i = 0; i < 10; i++)
            if (c == digit_codes[i]) return {1'b1, 8'(8'h30 + i)};
        if (c == 8'h29) return {1'b1, 8'h20};
        if (c == 8'h5A) return {1'b1, 8'h0D};
        if (c == 8'h66) return {1'b1, 8'h08};
        return 9'h000;
    endfunction
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic compare_all();
        chk("key_valid", {7'b0, key_valid}, {7'b0, mq.size() != 0});
        chk("key_ascii", key_ascii, mq.size() != 0 ? mq[0] : 8'h00);
        chk("shift_on", {7'b0, shift_on}, {7'b0, m_shift});
        chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
    endtask
    task automatic model_reset();
        mq.delete();
        m_shift = 0; m_ovf = 0; m_brk = 0; m_ext = 0; m_lmv = 0; m_lm = 8'h00;
    endtask
    // The model tracks the prefixes seen so far and decides what the completed key event means.
    task automatic model_step(input bit sv, input logic [7:0] code, input bit rdy, input bit clr);
        bit pop, push, sh;
        logic [8:0] r;
        pop  = rdy && mq.size() != 0;
        push = 0;
        r    = 9'h000;
        sh   = code == 8'h12 || code == 8'h59;
        if (sv) begin
            if (code == 8'hF0 && !m_brk) m_brk = 1;
            else if (code == 8'hE0 && !m_brk && !m_ext) m_ext = 1;
            else begin
                if (!m_ext && m_brk) begin
                    if (sh) m_shift = 0;
                    if (m_lmv && code == m_lm) m_lmv = 0;
                end else if (!m_ext && sh) m_shift = 1;
                else if (!m_ext) begin
                    r = ref_map(code, m_shift);
`ifdef KB_TYPEMATIC_FILTER_EN
                    push = r[8] && !(m_lmv && code == m_lm);
                    m_lm = code;
                    m_lmv = 1;
`else
                    push = r[8];
`endif
                end
                m_brk = 0;
                m_ext = 0;
            end
        end
        if (clr) m_ovf = 0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(r[7:0]);
            else m_ovf = 1;
        end
    endtask
    task automatic step(input bit sv, input logic [7:0] code, input bit rdy, input bit clr);
        @(negedge clk);
        compare_all();
        scan_valid = sv; scan_code = code; key_ready = rdy; ovf_clr = clr;
        model_step(sv, code, rdy, clr);
    endtask
    task automatic send(input logic [7:0] code);
        step(1, code, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask
    task automatic pop_one();
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; scan_valid = 0; key_ready = 0; ovf_clr = 0; scan_code = 8'h00;
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1;
    endtask
    logic [7:0] drain_exp [8] = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69};
    logic [7:0] fill_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    initial begin
        model_reset();
        do_reset();
        chk("reset_valid", {7'b0, key_valid}, 8'h00);
        chk("reset_ascii", key_ascii, 8'h00);
        chk("reset_shift", {7'b0, shift_on}, 8'h00);
        chk("reset_ovf", {7'b0, overflow}, 8'h00);
        send(8'h1C);
        chk("a_valid", {7'b0, key_valid}, 8'h01);
        chk("a_ascii", key_ascii, 8'h61);
        pop_one();
        chk("a_popped", {7'b0, key_valid}, 8'h00);
        send(8'h12);
        chk("shift_held", {7'b0, shift_on}, 8'h01);
        send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("shift_released", {7'b0, shift_on}, 8'h00);
        send(8'h1C);
        chk("upper_A", key_ascii, 8'h41);
        pop_one();
        chk("lower_a", key_ascii, 8'h61);
        pop_one();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h16);
        chk("ext_digit", key_ascii, 8'h31);
        pop_one();
        chk("ext_empty", {7'b0, key_valid}, 8'h00);
        foreach (fill_codes[i]) send(fill_codes[i]);
        chk("ovf_set", {7'b0, overflow}, 8'h01);
        foreach (drain_exp[i]) begin
            chk("drain", key_ascii, drain_exp[i]);
            pop_one();
        end
        chk("drain_empty", {7'b0, key_valid}, 8'h00);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        chk("ovf_cleared", {7'b0, overflow}, 8'h00);
        for (int i = 0; i < 8; i++) send(digit_codes[i]);
        step(1, 8'h1C, 1, 0);
        step(0, 8'h00, 0, 0);
        chk("full_pushpop_ovf", {7'b0, overflow}, 8'h00);
        chk("full_pushpop_head", key_ascii, 8'h31);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0);
        send(8'hF0);
        do_reset();
        send(8'h1C);
        chk("post_reset_a", key_ascii, 8'h61);
        pop_one();
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C);
        chk("repeat_first", key_ascii, 8'h61);
        pop_one();
`ifdef KB_TYPEMATIC_FILTER_EN
        chk("repeat_rest", {7'b0, key_valid}, 8'h00);
`else
        chk("repeat_rest", {7'b0, key_valid}, 8'h01);
`endif
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int k;
            logic [7:0] c;
            bit rdy, clr;
            k = $urandom_range(0, 11);
            c = k == 0 ? 8'hF0 : k == 1 ? 8'hE0 : k == 2 ? ($urandom_range(0, 1) ? 8'h12 : 8'h59) :
                k == 3 ? 8'($urandom) : k < 9 ? letter_codes[$urandom_range(0, 25)] :
                digit_codes[$urandom_range(0, 9)];
            rdy = (n / 200) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 1;
            clr = $urandom_range(0, 15) == 0;
            step(1, c, rdy, clr);
            step(0, 8'h00, $urandom_range(0, 1) == 1, 0);
        end
        step(0, 8'h00, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
